// File: rtl/keycode_pkg.sv
// Shared types and constants for the keycode event queue.
package keycode_pkg;

    typedef struct packed {
        logic       rpt;
        logic [7:0] code;
    } key_event_t;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam logic [7:0] KEY_W    = 8'h1A;
    localparam logic [7:0] KEY_A    = 8'h04;
    localparam logic [7:0] KEY_S    = 8'h16;
    localparam logic [7:0] KEY_D    = 8'h07;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head word is presented combinationally, zero when empty.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the slot the write pointer already aims at.
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/keycode_event_queue.sv
// Turns the level keycode into press / auto-repeat events and queues them for the game logic.
module keycode_event_queue
    import keycode_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int REPEAT_DELAY = 15,
    parameter int REPEAT_RATE  = 4
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [7:0]             keycode,
    input  logic                   frame_tick,
    input  logic                   evt_ready,
    input  logic                   clear_overflow,
    output logic                   evt_valid,
    output logic [7:0]             evt_code,
    output logic                   evt_repeat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int CW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE)) + 1;

    logic [7:0]    kc_q;
    logic [7:0]    kc_prev;
    rpt_state_t    state;
    rpt_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic          press;
    logic          evt_push;
    key_event_t    evt_data;
    key_event_t    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          drop;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            kc_q    <= KEY_NONE;
            kc_prev <= KEY_NONE;
        end else begin
            kc_q    <= keycode;
            kc_prev <= kc_q;
        end
    end

    assign press   = (kc_q != kc_prev) && (kc_q != KEY_NONE);
    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= RPT_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Release and new presses override whatever the repeat timer was doing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        evt_push  = 1'b0;
        evt_data  = '0;
        if (kc_q == KEY_NONE) begin
            state_nxt = RPT_IDLE;
            cnt_nxt   = '0;
        end else if (press) begin
            evt_push  = 1'b1;
            evt_data  = '{rpt: 1'b0, code: kc_q};
            state_nxt = RPT_DELAY;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RPT_DELAY: begin
                    if (frame_tick) begin
                        if (cnt_inc == CW'(REPEAT_DELAY)) begin
                            evt_push  = 1'b1;
                            evt_data  = '{rpt: 1'b1, code: kc_q};
                            state_nxt = RPT_REPEAT;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
                RPT_REPEAT: begin
                    if (frame_tick) begin
                        if (cnt_inc == CW'(REPEAT_RATE)) begin
                            evt_push = 1'b1;
                            evt_data = '{rpt: 1'b1, code: kc_q};
                            cnt_nxt  = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pop  = evt_valid & evt_ready;
    assign drop = evt_push & fifo_full & ~pop;

    sync_fifo #(
        .WIDTH ($bits(key_event_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (evt_push),
        .wr_data (evt_data),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign evt_valid  = ~fifo_empty;
    assign evt_code   = head.code;
    assign evt_repeat = head.rpt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keycode_event_queue.sv
// Bench for keycode_event_queue: vector table, directed corner sequences and random traffic vs a queue model.
module tb_keycode_event_queue;
    import keycode_pkg::*;

    localparam int DEPTH = 8;
    localparam int RD    = 4;
    localparam int RR    = 2;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic       frame_tick = 1'b0;
    logic       evt_ready = 1'b0;
    logic       clear_overflow = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_repeat;
    logic [$clog2(DEPTH):0] count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int seen_press = 0;
    int seen_rpt = 0;

    key_event_t m_q[$];
    logic [7:0] m_kc_q = 8'h00;
    logic [7:0] m_kc_prev = 8'h00;
    int         m_ticks = 0;
    bit         m_armed = 1'b0;
    bit         m_ovf = 1'b0;

    typedef struct {
        logic [7:0] kc;
        logic       tick;
        logic       rdy;
        logic       vld;
        logic [7:0] code;
        logic       rpt;
        logic [3:0] cnt;
        logic       ovf;
    } vec_t;
    vec_t tbl[13];
    logic [7:0] keys[5];

    keycode_event_queue #(.DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .keycode        (keycode),
        .frame_tick     (frame_tick),
        .evt_ready      (evt_ready),
        .clear_overflow (clear_overflow),
        .evt_valid      (evt_valid),
        .evt_code       (evt_code),
        .evt_repeat     (evt_repeat),
        .count          (count),
        .overflow       (overflow)
    );

    initial forever #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_kc_q    = 8'h00;
        m_kc_prev = 8'h00;
        m_ticks   = 0;
        m_armed   = 1'b0;
        m_ovf     = 1'b0;
    endtask

    // Events come from counting frame ticks since the last press of the held key.
    task automatic model_step();
        bit         ev;
        bit         pop;
        bit         drop;
        key_event_t e;
        ev = 1'b0;
        e  = '0;
        if (m_kc_q == 8'h00) begin
            m_ticks = 0;
            m_armed = 1'b0;
        end else if (m_kc_q != m_kc_prev) begin
            ev      = 1'b1;
            e       = '{rpt: 1'b0, code: m_kc_q};
            m_ticks = 0;
            m_armed = 1'b1;
        end else if (m_armed && frame_tick) begin
            m_ticks++;
            if (m_ticks == RD || (m_ticks > RD && (m_ticks - RD) % RR == 0)) begin
                ev = 1'b1;
                e  = '{rpt: 1'b1, code: m_kc_q};
            end
        end
        pop  = (m_q.size() > 0) && evt_ready;
        drop = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (ev) begin
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clear_overflow) m_ovf = 1'b0;
        m_kc_prev = m_kc_q;
        m_kc_q    = keycode;
    endtask

    task automatic check_model();
        key_event_t h;
        h = (m_q.size() > 0) ? m_q[0] : '0;
        chk("valid", 32'(evt_valid), 32'(m_q.size() > 0));
        chk("code", 32'(evt_code), 32'(h.code));
        chk("repeat", 32'(evt_repeat), 32'(h.rpt));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic cyc();
        @(posedge Clk);
        if (Reset_n) model_step();
        #1;
        check_model();
        if (evt_valid && evt_ready) begin
            if (evt_repeat) seen_rpt++;
            else seen_press++;
        end
    endtask

    initial begin
        keys[0] = KEY_NONE; keys[1] = KEY_A; keys[2] = KEY_D; keys[3] = KEY_S; keys[4] = KEY_W;
        tbl[0]  = '{8'h1A, 0, 0, 0, 8'h00, 0, 4'd0, 0};
        tbl[1]  = '{8'h1A, 0, 0, 1, 8'h1A, 0, 4'd1, 0};
        tbl[2]  = '{8'h1A, 0, 0, 1, 8'h1A, 0, 4'd1, 0};
        tbl[3]  = '{8'h1A, 0, 0, 1, 8'h1A, 0, 4'd1, 0};
        tbl[4]  = '{8'h1A, 0, 0, 1, 8'h1A, 0, 4'd1, 0};
        tbl[5]  = '{8'h00, 0, 0, 1, 8'h1A, 0, 4'd1, 0};
        tbl[6]  = '{8'h00, 0, 0, 1, 8'h1A, 0, 4'd1, 0};
        tbl[7]  = '{8'h04, 0, 1, 0, 8'h00, 0, 4'd0, 0};
        tbl[8]  = '{8'h04, 0, 0, 1, 8'h04, 0, 4'd1, 0};
        tbl[9]  = '{8'h07, 0, 0, 1, 8'h04, 0, 4'd1, 0};
        tbl[10] = '{8'h07, 0, 0, 1, 8'h04, 0, 4'd2, 0};
        tbl[11] = '{8'h07, 0, 1, 1, 8'h07, 0, 4'd1, 0};
        tbl[12] = '{8'h07, 0, 1, 0, 8'h00, 0, 4'd0, 0};

        // Reset and idle
        #2 Reset_n = 1'b0;
        model_reset();
        cyc();
        cyc();
        Reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("idle_valid", 32'(evt_valid), 32'd0);
            chk("idle_count", 32'(count), 32'd0);
            chk("idle_ovf", 32'(overflow), 32'd0);
        end

        // Vector table: press latency, hold, release, A->B change, pops
        for (int i = 0; i < 13; i++) begin
            keycode    = tbl[i].kc;
            frame_tick = tbl[i].tick;
            evt_ready  = tbl[i].rdy;
            cyc();
            chk("tbl_valid", 32'(evt_valid), 32'(tbl[i].vld));
            chk("tbl_code", 32'(evt_code), 32'(tbl[i].code));
            chk("tbl_repeat", 32'(evt_repeat), 32'(tbl[i].rpt));
            chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
            chk("tbl_ovf", 32'(overflow), 32'(tbl[i].ovf));
        end
        evt_ready = 1'b0;

        // Auto-repeat timing
        keycode = KEY_NONE;
        evt_ready = 1'b1;
        repeat (3) cyc();
        seen_press = 0;
        seen_rpt = 0;
        keycode = KEY_W;
        for (int t = 1; t <= 8; t++) begin
            repeat (99) cyc();
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
        end
        keycode = KEY_NONE;
        repeat (99) cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (5) cyc();
        chk("rpt_presses", 32'(seen_press), 32'd1);
        chk("rpt_repeats", 32'(seen_rpt), 32'd3);

        // Overflow and ordered drain
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            keycode = (i % 2 == 1) ? KEY_D : KEY_A;
            repeat (5) cyc();
        end
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_code", 32'(evt_code), (i % 2 == 1) ? 32'h07 : 32'h04);
            chk("drain_repeat", 32'(evt_repeat), 32'd0);
            cyc();
        end
        evt_ready = 1'b0;
        chk("drain_count", 32'(count), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        cyc();
        clear_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < 8; i++) begin
            keycode = (i % 2 == 0) ? KEY_D : KEY_A;
            repeat (4) cyc();
        end
        chk("full_count", 32'(count), 32'd8);
        keycode = KEY_S;
        cyc();
        evt_ready = 1'b1;
        cyc();
        evt_ready = 1'b0;
        chk("fullpp_count", 32'(count), 32'd8);
        chk("fullpp_ovf", 32'(overflow), 32'd0);
        evt_ready = 1'b1;
        repeat (7) cyc();
        chk("tail_code", 32'(evt_code), 32'h16);
        chk("tail_count", 32'(count), 32'd1);
        cyc();
        evt_ready = 1'b0;

        // Reset mid-operation with a key held
        keycode = KEY_A;
        repeat (3) cyc();
        keycode = KEY_W;
        repeat (3) cyc();
        keycode = KEY_D;
        repeat (3) cyc();
        chk("pre_rst_count", 32'(count), 32'd3);
        #2 Reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_code", 32'(evt_code), 32'd0);
        chk("rst_repeat", 32'(evt_repeat), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        cyc();
        cyc();
        Reset_n = 1'b1;
        cyc();
        chk("post_rst_count0", 32'(count), 32'd0);
        cyc();
        chk("post_rst_valid", 32'(evt_valid), 32'd1);
        chk("post_rst_code", 32'(evt_code), 32'h07);
        chk("post_rst_repeat", 32'(evt_repeat), 32'd0);
        chk("post_rst_count", 32'(count), 32'd1);
        repeat (5) cyc();
        chk("post_rst_hold", 32'(count), 32'd1);

        // Random traffic against the model: slow consumer, then fast consumer
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 7) == 0) keycode = keys[$urandom_range(0, 4)];
                frame_tick     = ($urandom_range(0, 9) == 0);
                evt_ready      = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                clear_overflow = ($urandom_range(0, 49) == 0);
                cyc();
            end
        end
        frame_tick = 1'b0;
        clear_overflow = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
